// File: rtl/alu_pkg.sv
// Shared ALU opcode encoding and datapath widths for decoder, ID/EX stage and ALU.
// No logic here; widths are the defaults the pipeline blocks are built around.
package alu_pkg;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] ADD  = 4'd0;
    localparam logic [OP_W-1:0] SUB  = 4'd1;
    localparam logic [OP_W-1:0] AND  = 4'd2;
    localparam logic [OP_W-1:0] OR   = 4'd3;
    localparam logic [OP_W-1:0] XOR  = 4'd4;
    localparam logic [OP_W-1:0] NOR  = 4'd5;
    localparam logic [OP_W-1:0] SLT  = 4'd6;
    localparam logic [OP_W-1:0] SLTU = 4'd7;
    localparam logic [OP_W-1:0] SLL  = 4'd8;
    localparam logic [OP_W-1:0] SRL  = 4'd9;
    localparam logic [OP_W-1:0] SRA  = 4'd10;
endpackage

// File: rtl/fwd_select.sv
// Operand forwarding priority mux: r0 -> 0, then EX, EX/MEM, MEM/WB, register file.
// Purely combinational, no latency; no flow control of its own.
module fwd_select #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] addr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              ex_write,
    input  logic [REG_AW-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              exm_write,
    input  logic [REG_AW-1:0] exm_addr,
    input  logic [DATA_W-1:0] exm_data,
    input  logic              mwb_write,
    input  logic [REG_AW-1:0] mwb_addr,
    input  logic [DATA_W-1:0] mwb_data,
    output logic [DATA_W-1:0] data
);
    always_comb begin
        data = rf_data;
        if (addr == '0)
            data = '0;
        else if (ex_write && ex_addr == addr)
            data = ex_data;
        else if (exm_write && exm_addr == addr)
            data = exm_data;
        else if (mwb_write && mwb_addr == addr)
            data = mwb_data;
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register feeding the ALU; operands resolved by forwarding at capture time.
// Latency 1 cycle; holds all outputs while ex_ready is low, flush drops held and incoming.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [OP_W-1:0]   id_op,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic              id_use_imm,
    input  logic              id_use_shamt,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_reg_write,
    input  logic              flush,
    input  logic              ex_ready,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd_addr,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mwb_reg_write,
    input  logic [REG_AW-1:0] mwb_rd_addr,
    input  logic [DATA_W-1:0] mwb_result,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_in1,
    output logic [DATA_W-1:0] ex_in2,
    output logic [OP_W-1:0]   ex_op,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_reg_write,
    output logic [31:0]       stall_cycles
);
    import alu_pkg::ADD;

    logic              valid_q;
    logic [DATA_W-1:0] in1_q;
    logic [DATA_W-1:0] in2_q;
    logic [OP_W-1:0]   op_q;
    logic [REG_AW-1:0] rd_q;
    logic              rw_q;
    logic [31:0]       stall_q;

    logic              fire;
    logic              capture;
    logic              ex_fwd;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;

    assign id_ready = !valid_q || ex_ready;
    assign fire     = valid_q && ex_ready;
    assign capture  = id_valid && id_ready;
    // The held instruction's result is only forwardable in the cycle it leaves.
    assign ex_fwd   = fire && rw_q;

    fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .addr(id_rs_addr), .rf_data(id_rs_data),
        .ex_write(ex_fwd), .ex_addr(rd_q), .ex_data(ex_result),
        .exm_write(exm_reg_write), .exm_addr(exm_rd_addr), .exm_data(exm_result),
        .mwb_write(mwb_reg_write), .mwb_addr(mwb_rd_addr), .mwb_data(mwb_result),
        .data(rs_fwd)
    );

    fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .addr(id_rt_addr), .rf_data(id_rt_data),
        .ex_write(ex_fwd), .ex_addr(rd_q), .ex_data(ex_result),
        .exm_write(exm_reg_write), .exm_addr(exm_rd_addr), .exm_data(exm_result),
        .mwb_write(mwb_reg_write), .mwb_addr(mwb_rd_addr), .mwb_data(mwb_result),
        .data(rt_fwd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            in1_q   <= '0;
            in2_q   <= '0;
            op_q    <= ADD;
            rd_q    <= '0;
            rw_q    <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (capture) begin
            valid_q <= 1'b1;
            in1_q   <= id_use_shamt ? DATA_W'(id_shamt) : rs_fwd;
            in2_q   <= id_use_imm ? id_imm : rt_fwd;
            op_q    <= id_op;
            rd_q    <= id_rd_addr;
            rw_q    <= id_reg_write;
        end else if (fire) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_q <= '0;
        else if (valid_q && !ex_ready && stall_q != 32'hFFFF_FFFF)
            stall_q <= stall_q + 32'd1;
    end

    assign ex_valid     = valid_q;
    assign ex_in1       = in1_q;
    assign ex_in2       = in2_q;
    assign ex_op        = op_q;
    assign ex_rd_addr   = rd_q;
    assign ex_reg_write = rw_q && valid_q;
    assign stall_cycles = stall_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, forwarding priority, hold, flush, drain,
// shift/immediate select, stall saturation and reset priority.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic        id_ready;
    logic [3:0]  id_op;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt;
    logic        id_use_imm, id_use_shamt, id_reg_write;
    logic        flush, ex_ready;
    logic [31:0] ex_result;
    logic        exm_reg_write, mwb_reg_write;
    logic [4:0]  exm_rd_addr, mwb_rd_addr;
    logic [31:0] exm_result, mwb_result;
    logic        ex_valid;
    logic [31:0] ex_in1, ex_in2;
    logic [3:0]  ex_op;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write;
    logic [31:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_ready(id_ready), .id_op(id_op),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_shamt(id_shamt),
        .id_use_imm(id_use_imm), .id_use_shamt(id_use_shamt),
        .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .flush(flush), .ex_ready(ex_ready), .ex_result(ex_result),
        .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd_addr(mwb_rd_addr), .mwb_result(mwb_result),
        .ex_valid(ex_valid), .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_op(ex_op),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .stall_cycles(stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_op = 0; id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0;
        id_use_imm = 0; id_use_shamt = 0; id_reg_write = 0; flush = 0;
        ex_result = 0; exm_reg_write = 0; exm_rd_addr = 0; exm_result = 0;
        mwb_reg_write = 0; mwb_rd_addr = 0; mwb_result = 0;
    endtask

    task automatic instr(input logic [3:0] op, input logic [4:0] rs, input logic [31:0] rsd,
                         input logic [4:0] rt, input logic [31:0] rtd,
                         input logic [4:0] rd, input logic rw);
        id_valid = 1; id_op = op; id_rs_addr = rs; id_rs_data = rsd;
        id_rt_addr = rt; id_rt_data = rtd; id_rd_addr = rd; id_reg_write = rw;
        id_use_imm = 0; id_use_shamt = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1; ex_ready = 0;

        // 1. reset and a plain capture
        tick(); tick();
        chk("rst_valid", ex_valid, 0);
        chk("rst_stall", stall_cycles, 0);
        chk("rst_regwr", ex_reg_write, 0);
        chk("rst_ready", id_ready, 1);
        reset = 0; ex_ready = 1;
        instr(alu_pkg::ADD, 5'd3, 32'd5, 5'd4, 32'd7, 5'd9, 1);
        tick();
        chk("cap_in1", ex_in1, 32'd5);
        chk("cap_in2", ex_in2, 32'd7);
        chk("cap_op", ex_op, 0);
        chk("cap_valid", ex_valid, 1);
        chk("cap_rd", ex_rd_addr, 9);
        chk("cap_regwr", ex_reg_write, 1);

        // 2. forwarding priority; first load an instruction writing r8
        instr(alu_pkg::ADD, 5'd0, 32'd0, 5'd0, 32'd0, 5'd8, 1);
        tick();
        ex_result = 32'h11;
        exm_reg_write = 1; exm_rd_addr = 8; exm_result = 32'h22;
        mwb_reg_write = 1; mwb_rd_addr = 8; mwb_result = 32'h33;
        instr(alu_pkg::ADD, 5'd8, 32'h44, 5'd0, 32'h45, 5'd1, 0);
        tick();
        chk("fwd_ex", ex_in1, 32'h11);
        chk("fwd_r0_rt", ex_in2, 32'h0);
        instr(alu_pkg::ADD, 5'd8, 32'h44, 5'd1, 32'h46, 5'd1, 0);
        tick();
        chk("fwd_exm", ex_in1, 32'h22);
        chk("fwd_none_rt", ex_in2, 32'h46);
        exm_reg_write = 0;
        instr(alu_pkg::ADD, 5'd8, 32'h44, 5'd8, 32'h47, 5'd0, 1);
        tick();
        chk("fwd_mwb", ex_in1, 32'h33);
        chk("fwd_mwb_rt", ex_in2, 32'h33);
        ex_result = 32'h99;
        exm_reg_write = 1; exm_rd_addr = 0; exm_result = 32'h22;
        mwb_reg_write = 1; mwb_rd_addr = 0; mwb_result = 32'h33;
        instr(alu_pkg::ADD, 5'd0, 32'h55, 5'd0, 32'h56, 5'd2, 1);
        tick();
        chk("fwd_r0", ex_in1, 32'h0);

        // 3. backpressure: outputs freeze, forwarding is not re-sampled
        exm_reg_write = 0; mwb_reg_write = 0;
        instr(alu_pkg::SUB, 5'd5, 32'h77, 5'd6, 32'h88, 5'd2, 1);
        tick();
        chk("bp_pre_in1", ex_in1, 32'h77);
        ex_ready = 0;
        exm_reg_write = 1; exm_rd_addr = 8; exm_result = 32'h90;
        instr(alu_pkg::OR, 5'd8, 32'h1, 5'd6, 32'h2, 5'd3, 0);
        #1;
        chk("bp_ready", id_ready, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            exm_result = 32'h90 + 32'(i);
            chk("bp_in1", ex_in1, 32'h77);
            chk("bp_in2", ex_in2, 32'h88);
            chk("bp_op", ex_op, alu_pkg::SUB);
            chk("bp_valid", ex_valid, 1);
            chk("bp_stall", stall_cycles, 32'(i));
        end
        exm_result = 32'hAB;
        ex_ready = 1;
        tick();
        chk("bp_release_in1", ex_in1, 32'hAB);
        chk("bp_release_op", ex_op, alu_pkg::OR);
        chk("bp_release_regwr", ex_reg_write, 0);
        exm_reg_write = 0;

        // 4. flush with a simultaneous capture, then recovery; flush during hold; drain
        instr(alu_pkg::AND, 5'd3, 32'hDEAD, 5'd4, 32'hBEEF, 5'd7, 1);
        flush = 1;
        #1;
        chk("fl_ready", id_ready, 1);
        tick();
        flush = 0;
        chk("fl_valid", ex_valid, 0);
        chk("fl_regwr", ex_reg_write, 0);
        instr(alu_pkg::XOR, 5'd3, 32'h12, 5'd4, 32'h34, 5'd7, 1);
        tick();
        chk("fl_next_valid", ex_valid, 1);
        chk("fl_next_in1", ex_in1, 32'h12);
        chk("fl_next_op", ex_op, alu_pkg::XOR);
        ex_ready = 0; flush = 1;
        tick();
        flush = 0;
        chk("fl_hold_valid", ex_valid, 0);
        chk("fl_hold_stall", stall_cycles, 32'd4);
        ex_ready = 1;
        instr(alu_pkg::NOR, 5'd1, 32'h61, 5'd2, 32'h62, 5'd6, 1);
        tick();
        id_valid = 0;
        tick();
        chk("drain_valid", ex_valid, 0);
        chk("drain_regwr", ex_reg_write, 0);
        chk("drain_in1", ex_in1, 32'h61);

        // 5. shift amount and immediate selection
        instr(alu_pkg::SRA, 5'd5, 32'h1234, 5'd7, 32'h8000_0000, 5'd4, 1);
        id_use_shamt = 1; id_shamt = 5'd4;
        tick();
        chk("sh_in1", ex_in1, 32'd4);
        chk("sh_in2", ex_in2, 32'h8000_0000);
        chk("sh_op", ex_op, alu_pkg::SRA);
        id_use_shamt = 0; id_use_imm = 1; id_imm = 32'hFFFF_FFF0; id_op = alu_pkg::ADD;
        tick();
        chk("imm_in2", ex_in2, 32'hFFFF_FFF0);
        chk("imm_in1", ex_in1, 32'h1234);

        // 6. saturation, then reset beating flush and capture
        ex_ready = 0;
        force dut.stall_q = 32'hFFFF_FFFD;
        tick();
        release dut.stall_q;
        chk("sat_preload", stall_cycles, 32'hFFFF_FFFD);
        tick();
        chk("sat_fe", stall_cycles, 32'hFFFF_FFFE);
        tick();
        chk("sat_ff", stall_cycles, 32'hFFFF_FFFF);
        tick();
        chk("sat_hold", stall_cycles, 32'hFFFF_FFFF);
        reset = 1; flush = 1; ex_ready = 1;
        instr(alu_pkg::SUB, 5'd3, 32'h5, 5'd4, 32'h6, 5'd9, 1);
        tick();
        reset = 0; flush = 0; id_valid = 0;
        chk("rp_valid", ex_valid, 0);
        chk("rp_in1", ex_in1, 0);
        chk("rp_in2", ex_in2, 0);
        chk("rp_op", ex_op, alu_pkg::ADD);
        chk("rp_rd", ex_rd_addr, 0);
        chk("rp_regwr", ex_reg_write, 0);
        chk("rp_stall", stall_cycles, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register that directly feeds the ALU.
- Captures decoded instruction fields and resolves register operands by forwarding at capture time.
- Selects immediate or shift-amount sources and presents registered In1/In2/OP to the ALU.
- Uses a valid/ready handshake, with flush and a saturating stall counter.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register address width
OP_W, 4, ALU opcode width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
id_valid  in  1  decode stage offers an instruction
id_ready  out  1  stage can accept this cycle
id_op  in  OP_W  ALU opcode (ADD=0 … SRA=10)
id_rs_addr  in  REG_AW  source-1 register
id_rt_addr  in  REG_AW  source-2 register
id_rs_data  in  DATA_W  register-file value for rs
id_rt_data  in  DATA_W  register-file value for rt
id_imm  in  DATA_W  extended immediate
id_shamt  in  5  shift amount field
id_use_imm  in  1  In2 := imm
id_use_shamt  in  1  In1 := zero-extended shamt
id_rd_addr  in  REG_AW  destination register
id_reg_write  in  1  instruction writes rd
flush  in  1  kill held and incoming instruction
ex_ready  in  1  downstream consumes the ALU result this cycle
ex_result  in  DATA_W  ALU result of the currently held instruction (bypass)
exm_reg_write  in  1  EX/MEM stage writes
exm_rd_addr  in  REG_AW  EX/MEM destination
exm_result  in  DATA_W  EX/MEM value
mwb_reg_write  in  1  MEM/WB stage writes
mwb_rd_addr  in  REG_AW  MEM/WB destination
mwb_result  in  DATA_W  MEM/WB value
ex_valid  out  1  held instruction is valid
ex_in1  out  DATA_W  ALU In1
ex_in2  out  DATA_W  ALU In2
ex_op  out  OP_W  ALU OP
ex_rd_addr  out  REG_AW  destination of held instruction
ex_reg_write  out  1  stored reg_write AND ex_valid
stall_cycles  out  32  saturating count of stalled cycles

Behaviour:
- **Clock and reset:** single clock domain. Synchronous active-high reset clears all registers to 0 (ex_op=ADD). ex_valid=0 and stall_cycles=0 on reset. Reset overrides flush and capture.
- **Ready:** id_ready = !ex_valid || ex_ready (combinational). There is no dependency on id_valid.
- **Fire and capture:** fire = ex_valid && ex_ready. Capture occurs when id_valid && id_ready; outputs update on the next edge, giving 1-cycle latency.
- **Drain:** on fire without capture, ex_valid goes 0 next cycle. Data registers hold their values; ex_reg_write is masked to 0.
- **Hold:** when ex_valid && !ex_ready, all outputs are frozen. Forwarding sources are NOT re-sampled while holding.
- **Flush:**
  - ex_valid goes 0 next cycle.
  - Any instruction accepted in the same cycle is discarded; upstream treats it as consumed.
  - Flush wins over capture and over hold.
- **Operand resolution at capture** (per source address a, value v):
  - If a==0, the result is 0; no forwarding for register 0.
  - Else, if fire && ex_reg_write && ex_rd_addr==a, use ex_result.
  - Else, if exm_reg_write && exm_rd_addr==a, use exm_result.
  - Else, if mwb_reg_write && mwb_rd_addr==a, use mwb_result.
  - Else, use v.
  - Priority is strictly in the order above.
- **Operand select:**
  - In1 = id_use_shamt ? {27'b0, id_shamt} : fwd(rs).
  - In2 = id_use_imm ? id_imm : fwd(rt).
  - Shift ops consume In1[4:0] as the amount and In2 as the value, so variable shifts take rs through fwd.
- **Stall counter:** stall_cycles increments by 1 each cycle ex_valid && !ex_ready and saturates at 32'hFFFF_FFFF. It is cleared only by reset.
- **Opcodes:** ex_op is passed through unchanged. Undefined opcodes are not checked here.

Decomposition:
- **Shared package alu_pkg:**
  - Opcode localparams ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLTU=7, SLL=8, SRL=9, SRA=10.
  - DATA_W and REG_AW.
  - Used by this block, the ALU, and the decoder.
- **Sub-module fwd_select:** combinational priority mux implementing the operand-resolution rule. Instantiated twice (rs, rt).

Test Plan:
1. **Reset and simple capture:** reset high 2 cycles → ex_valid=0, stall_cycles=0, ex_reg_write=0. Then id_valid=1, ADD, rs=3 (data 5), rt=4 (data 7), ex_ready=1 → next cycle ex_in1=5, ex_in2=7, ex_op=0, ex_valid=1.
2. **Forward priority:** held instr writes r8, fire, ex_result=0x11; exm writes r8=0x22; mwb writes r8=0x33; new instr rs=8 → ex_in1=0x11. Drop the EX match → 0x22. Drop EX/MEM → 0x33. rs=0 with all sources targeting r0 → ex_in1=0.
3. **Backpressure:** ex_ready=0 for 3 cycles while valid → id_ready=0, outputs frozen, stall_cycles=3. Changing exm_result meanwhile does not alter ex_in1.
4. **Flush:** flush=1 in the same cycle as id_valid=1 and id_ready=1 → next cycle ex_valid=0 and ex_reg_write=0. Following cycle, a new capture proceeds normally.
5. **Shift/immediate:** SRA with use_shamt=1, shamt=4, rt data 0x8000_0000 → ex_in1=4, ex_in2=0x8000_0000, ex_op=10. Then use_imm=1, imm=0xFFFF_FFF0 → ex_in2=0xFFFF_FFF0.
6. **Saturation and reset priority:** force stall_cycles near max (preload via long stall or bind) → stays 0xFFFF_FFFF. Reset asserted together with flush and id_valid → all outputs 0 next cycle.
